// File: rtl/axi4_lite_master_arb.sv
// Two-requester AXI4-Lite master with round-robin arbitration.
// Each granted request runs one single-beat write (AW -> W -> B) or read (AR -> R)
// on the master port. A one-cycle done pulse goes back to the owning requester.
//
//  state | meaning
//  IDLE  | arbitrate between eligible requesters; completion pulse is visible here
//  ADDR  | AWVALID or ARVALID held until the slave accepts the address
//  DATA  | write: WVALID held until WREADY; read: RREADY until RVALID
//  RESP  | write only: BREADY until BVALID
module axi4_lite_master_arb #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic [1:0]                    req_i,
    input  logic [1:0]                    we_i,
    input  logic [2*ADDR_WIDTH-1:0]       addr_i,
    input  logic [2*DATA_WIDTH-1:0]       wdata_i,
    input  logic [2*(DATA_WIDTH/8)-1:0]   wstrb_i,
    output logic [1:0]                    done_o,
    output logic [DATA_WIDTH-1:0]         rdata_o,
    output logic [1:0]                    resp_o,
    output logic [ADDR_WIDTH-1:0]         AWADDR,
    output logic [2:0]                    AWPROT,
    output logic                          AWVALID,
    input  logic                          AWREADY,
    output logic [DATA_WIDTH-1:0]         WDATA,
    output logic [(DATA_WIDTH/8)-1:0]     WSTRB,
    output logic                          WVALID,
    input  logic                          WREADY,
    input  logic [1:0]                    BRESP,
    input  logic                          BVALID,
    output logic                          BREADY,
    output logic [ADDR_WIDTH-1:0]         ARADDR,
    output logic [2:0]                    ARPROT,
    output logic                          ARVALID,
    input  logic                          ARREADY,
    input  logic [DATA_WIDTH-1:0]         RDATA,
    input  logic [1:0]                    RRESP,
    input  logic                          RVALID,
    output logic                          RREADY
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]            r_state;
    logic                  r_grant;
    logic                  r_last_grant;
    logic                  r_we;
    logic [1:0]            r_done;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_resp;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_WIDTH-1:0] r_wstrb;
    logic                  r_awvalid;
    logic                  r_wvalid;
    logic                  r_bready;
    logic                  r_arvalid;
    logic                  r_rready;

    logic [1:0]            w_elig;
    logic                  w_gnt_valid;
    logic                  w_gnt_id;
    logic                  w_sel_we;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic [STRB_WIDTH-1:0] w_sel_wstrb;
    logic [1:0]            w_done_onehot;

    // Round-robin pick; a requester whose done pulse is showing is not eligible,
    // so a level held one cycle past completion is not mistaken for a new request.
    always_comb begin
        w_elig      = req_i & ~r_done;
        w_gnt_valid = |w_elig;
        w_gnt_id    = 1'b0;
        case (w_elig)
            2'b01:   w_gnt_id = 1'b0;
            2'b10:   w_gnt_id = 1'b1;
            2'b11:   w_gnt_id = ~r_last_grant;
            default: w_gnt_id = 1'b0;
        endcase
    end

    // Payload of the requester being granted this cycle.
    always_comb begin
        w_sel_we    = w_gnt_id ? we_i[1] : we_i[0];
        w_sel_addr  = w_gnt_id ? addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : addr_i[ADDR_WIDTH-1:0];
        w_sel_wdata = w_gnt_id ? wdata_i[2*DATA_WIDTH-1:DATA_WIDTH] : wdata_i[DATA_WIDTH-1:0];
        w_sel_wstrb = w_gnt_id ? wstrb_i[2*STRB_WIDTH-1:STRB_WIDTH] : wstrb_i[STRB_WIDTH-1:0];
        w_done_onehot = r_grant ? 2'b10 : 2'b01;
    end

    // Transaction sequencer: every output is a register updated here.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state      <= S_IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_we         <= 1'b0;
            r_done       <= 2'b00;
            r_rdata      <= '0;
            r_resp       <= 2'b00;
            r_awaddr     <= '0;
            r_araddr     <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_bready     <= 1'b0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
        end else begin
            r_done <= 2'b00;
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_valid) begin
                        r_grant      <= w_gnt_id;
                        r_last_grant <= w_gnt_id;
                        r_we         <= w_sel_we;
                        if (w_sel_we) begin
                            r_awaddr  <= w_sel_addr;
                            r_wdata   <= w_sel_wdata;
                            r_wstrb   <= w_sel_wstrb;
                            r_awvalid <= 1'b1;
                        end else begin
                            r_araddr  <= w_sel_addr;
                            r_arvalid <= 1'b1;
                        end
                        r_state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (r_we) begin
                        if (AWREADY) begin
                            r_awvalid <= 1'b0;
                            r_wvalid  <= 1'b1;
                            r_state   <= S_DATA;
                        end
                    end else if (ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (r_we) begin
                        if (WREADY) begin
                            r_wvalid <= 1'b0;
                            r_bready <= 1'b1;
                            r_state  <= S_RESP;
                        end
                    end else if (RVALID) begin
                        r_rready <= 1'b0;
                        r_rdata  <= RDATA;
                        r_resp   <= RRESP;
                        r_done   <= w_done_onehot;
                        r_state  <= S_IDLE;
                    end
                end
                S_RESP: begin
                    if (BVALID) begin
                        r_bready <= 1'b0;
                        r_resp   <= BRESP;
                        r_done   <= w_done_onehot;
                        r_state  <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign done_o  = r_done;
    assign rdata_o = r_rdata;
    assign resp_o  = r_resp;
    assign AWADDR  = r_awaddr;
    assign AWPROT  = 3'b000;
    assign AWVALID = r_awvalid;
    assign WDATA   = r_wdata;
    assign WSTRB   = r_wstrb;
    assign WVALID  = r_wvalid;
    assign BREADY  = r_bready;
    assign ARADDR  = r_araddr;
    assign ARPROT  = 3'b000;
    assign ARVALID = r_arvalid;
    assign RREADY  = r_rready;

endmodule

// File: doc/axi4_lite_master_arb.md
Name: axi4_lite_master_arb

Overview:
Two-requester AXI4-Lite master controller. It accepts simple single-beat read/write requests from two local requesters, arbitrates round-robin, and sequences one AXI4-Lite master port through the AW/W/B or AR/R handshakes. It sits between the local engines and the AXI4-Lite slave. It uses the state encoding from axi4_lite_Defs (IDLE, ADDR, DATA, RESP).

Parameters:
ADDR_WIDTH, 32 (axi4_lite_Defs::Addr_Width), address width
DATA_WIDTH, 32 (axi4_lite_Defs::Data_Width), data width; STRB_WIDTH = DATA_WIDTH/8

Ports:
ACLK  in  1  clock, all logic on rising edge
ARESETN  in  1  asynchronous active-low reset
req_i  in  2  per-requester request level; bit n = requester n
we_i  in  2  1 = write, 0 = read
addr_i  in  2*ADDR_WIDTH  request address; slice n = requester n
wdata_i  in  2*DATA_WIDTH  write data
wstrb_i  in  2*STRB_WIDTH  write strobes
done_o  out  2  one-cycle completion pulse per requester
rdata_o  out  DATA_WIDTH  read data, valid while done_o != 0
resp_o  out  2  BRESP/RRESP, valid while done_o != 0
AWADDR, AWPROT(3), AWVALID out; AWREADY in
WDATA, WSTRB, WVALID out; WREADY in
BRESP(2), BVALID in; BREADY out
ARADDR, ARPROT(3), ARVALID out; ARREADY in
RDATA, RRESP(2), RVALID in; RREADY out

Behaviour:
- Reset (async assert, sync release): state=IDLE; all VALID/READY outputs 0; done_o=0; rdata_o=0; resp_o=0; AW/AR/W payload 0; last_grant=1, so requester 0 wins the first tie.
- All outputs are registered. AWPROT and ARPROT are constant 3'b000.
- Arbitration happens in IDLE only. The eligible set is req_i & ~done_o; the requester whose done pulse is high this cycle is ignored.
  - One eligible requester: grant it.
  - Both eligible: grant the requester != last_grant.
  - On grant, latch grant id, we, addr, wdata and wstrb, update last_grant, and go to ADDR.
- ADDR:
  - Write: AWVALID=1 and AWADDR held stable until AWREADY, then go to DATA.
  - Read: ARVALID=1 until ARREADY, then go to DATA.
  - VALID is never dropped before its READY.
- DATA:
  - Write: WVALID=1 with WDATA/WSTRB held until WREADY, then go to RESP.
  - Read: RREADY=1; on RVALID capture RDATA into rdata_o and RRESP into resp_o, pulse done_o[grant] for one cycle, and go to IDLE.
- RESP (write only): BREADY=1; on BVALID capture BRESP into resp_o, pulse done_o[grant], and go to IDLE. rdata_o is unchanged.
- done_o, rdata_o and resp_o update in the cycle after the completing handshake, coincident with state=IDLE.
- rdata_o and resp_o hold until the next completion.
- Latency with a zero-wait slave, request seen in IDLE at cycle N:
  - Write: AWVALID at N+1, WVALID at N+2, BREADY at N+3, done at N+4.
  - Read: ARVALID at N+1, RREADY at N+2, done at N+3.
- A new grant can be made in the same IDLE cycle that carries a done pulse, provided the other requester is eligible.
- Requester contract: hold req_i and payload until done_o; drop req_i in the done cycle. If req_i is still high in the cycle after done, it is a new request.
- Error responses (SLVERR/DECERR) pass through on resp_o with no retry.
- A deasserted req_i after grant does not abort; the transaction completes.
- Reset mid-transaction: immediately drops all VALID/READY outputs and done_o, returns to IDLE, and sets last_grant=1.
- No timeout. A slave that never responds stalls the arbiter.

Test Plan:
1. Reset then req_i=2'b01, we=1, addr0=0x1000, wdata0=0xDEADBEEF, wstrb0=0xF, slave zero-wait → AWVALID cycle 1 with AWADDR=0x1000, WVALID cycle 2 with WDATA=0xDEADBEEF, BREADY cycle 3, done_o=2'b01 cycle 4 with resp_o=0.
2. req_i=2'b10 read addr1=0x20, slave RDATA=0x12345678, RRESP=2 → ARADDR=0x20; done_o=2'b10, rdata_o=0x12345678, resp_o=2'b10 at N+3.
3. Both requesting continuously, back-to-back writes → grants alternate 0,1,0,1 with no requester served twice in a row; second AWVALID rises in the cycle after the first done.
4. Slave holds AWREADY=0 for 5 cycles, then WREADY=0 for 3 cycles → AWVALID/AWADDR and WVALID/WDATA stay stable throughout; done arrives 8 cycles later than the zero-wait case.
5. ARESETN pulsed low during DATA of a read → RREADY/ARVALID drop asynchronously; done_o=0; after release req_i=2'b11 grants requester 0 first.
6. Requester 0 keeps req_i high one cycle after its done while requester 1 is idle → the done cycle does not re-grant 0; the next cycle grants 0 as a new request.
